filter_chain: RTL and testbench
===============================

Name: filter_chain

Overview:
- Parametrised successor to the single-bit shift/parity filter stage and its two-stage cascade.
- STAGES identical filter stages connected in a pipeline, with a WIDTH-bit data path.
- Adds ready/valid backpressure, a per-beat shift/rotate mode, a synchronous flush and an occupancy count.
- Sits between a stream producer and consumer; replaces hand-instantiated cascades of fixed 16-bit filters.

Parameters:
- STAGES, 2, number of pipeline stages (>=1).
- WIDTH, 16, data width in bits (>=2).
- CW, $clog2(STAGES+1), width of io_count.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- io_x_data  in  WIDTH  input beat data.
- io_x_valid  in  1  input beat valid.
- io_x_parity  in  1  input beat parity/carry bit.
- io_x_mode  in  1  per-beat mode: 0 = shift, 1 = rotate.
- io_x_ready  out  1  chain can accept a beat this cycle.
- io_y_data  out  WIDTH  output beat data.
- io_y_valid  out  1  output beat valid.
- io_y_parity  out  1  output beat parity/carry bit.
- io_y_ready  in  1  consumer accepts the output beat.
- io_flush  in  1  synchronous discard of all in-flight beats.
- io_count  out  CW  number of occupied stages.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous, active-low.
- Reset state, while reset=0 and after release: all stage valid/data/parity/mode registers 0; io_y_valid=0, io_y_data=0, io_y_parity=0, io_count=0.
- io_x_ready is forced to 0 while reset=0.
- Per-stage storage: valid_i, data_i[WIDTH], par_i, mode_i.
- Stage i output: stage i-1 for i>0, input port for i=0. The last stage drives the io_y_* outputs.
- Stage transform, applied when a beat is loaded into a stage; (d, p, m) are the upstream values:
  - Shift mode (m=0): d' = {d[WIDTH-2:0], p}, p' = d[WIDTH-1].
  - Rotate mode (m=1): d' = {d[WIDTH-2:0], d[WIDTH-1]}, p' = p.
  - m' = m. The mode travels with the beat, so a mode change never affects beats already in flight.
- Handshake:
  - ready_last = !valid_last || io_y_ready.
  - ready_i = !valid_i || ready_{i+1}.
  - io_x_ready = ready_0 && !io_flush. This is a combinational path from io_y_ready; accepted.
  - Stage i loads when ready_i and the upstream beat is valid.
  - Stage i clears valid_i when it hands off its beat and receives none.
  - Input transfer occurs when io_x_valid && io_x_ready. Output transfer occurs when io_y_valid && io_y_ready.
- Latency: a beat accepted at edge k appears on io_y_* after edge k+STAGES-1, i.e. exactly STAGES cycles, when no stalls occur.
- Throughput: 1 beat/cycle sustained while io_y_ready=1.
- Stall: with io_y_ready=0, io_y_data, io_y_parity and io_y_valid hold stable. Bubbles compress, so a later stage that holds no valid beat still loads from its upstream stage.
- Full condition: all STAGES valid and io_y_ready=0 gives io_x_ready=0.
- Simultaneous push and pop when full: a beat is accepted in the same cycle the head beat leaves.
- io_count:
  - Registered; increments by 1 on an input transfer only, decrements by 1 on an output transfer only, unchanged when both or neither occur.
  - Always equals the popcount of the valid_i bits. Saturation is impossible by construction.
- Flush:
  - io_flush=1 at a clock edge clears all valid_i and sets io_count to 0. Data/parity registers need not clear.
  - No input is accepted in that cycle. An output transfer in the same cycle still counts as delivered.
  - Flush has priority over all loads.
- Reset mid-operation: an asynchronous clear of all state. Outputs go to their reset values immediately, without waiting for a clock edge.
- Ordering: strictly FIFO; no beat is dropped or duplicated except by flush or reset.

Test Plan:
- Single beat (WIDTH=16, STAGES=2): io_x_data=0xA5C3, parity=1, mode=0, one cycle, io_y_ready=1 -> io_y_valid=1 for one cycle exactly 2 cycles later, with io_y_data=0x970F, io_y_parity=0; io_count goes 1,1,0.
- Rotate mode: same beat with mode=1 -> io_y_data=0x970E, io_y_parity=1.
- Backpressure: hold io_y_ready=0 and offer beats 0x0001, 0x0002, 0x0003 -> first two are accepted, then io_x_ready=0 and io_count=2. Release io_y_ready -> outputs arrive in order with mode-0 transforms: 0x0004, then 0x0008. Parity 0 throughout. The third beat follows.
- Streaming: 100 back-to-back random beats with random mode and io_y_ready=1 -> one output per cycle after 2-cycle latency; every beat matches the reference model.
- Flush: load 2 beats with io_y_ready=0, pulse io_flush -> next cycle io_y_valid=0, io_count=0. io_x_ready=0 during the flush cycle and 1 afterwards. The held beats are never emitted.
- Async reset: drive reset=0 between clock edges while the chain is full -> io_y_valid, io_count and io_x_ready go to 0 immediately. After release, a new beat passes with normal 2-cycle latency.

Source files
------------

// File: rtl/filter_chain_if.sv
// Stream bundle for filter_chain: producer side (io_x_*), consumer side (io_y_*),
// plus flush and occupancy.
interface filter_chain_if #(
  parameter int WIDTH = 16,
  parameter int CW    = 2
);
  logic [WIDTH-1:0] io_x_data;
  logic             io_x_valid;
  logic             io_x_parity;
  logic             io_x_mode;
  logic             io_x_ready;
  logic [WIDTH-1:0] io_y_data;
  logic             io_y_valid;
  logic             io_y_parity;
  logic             io_y_ready;
  logic             io_flush;
  logic [CW-1:0]    io_count;

  modport master (
    output io_x_data, io_x_valid, io_x_parity, io_x_mode, io_y_ready, io_flush,
    input  io_x_ready, io_y_data, io_y_valid, io_y_parity, io_count
  );

  modport slave (
    input  io_x_data, io_x_valid, io_x_parity, io_x_mode, io_y_ready, io_flush,
    output io_x_ready, io_y_data, io_y_valid, io_y_parity, io_count
  );
endinterface

// File: rtl/filter_chain.sv
// STAGES-deep shift/rotate filter pipeline with ready/valid backpressure,
// synchronous flush and a registered occupancy count.
module filter_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             ready_i,
  input  logic             up_vld_i,
  input  logic [WIDTH-1:0] up_data_i,
  input  logic             up_par_i,
  input  logic             up_mode_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o,
  output logic             par_o,
  output logic             mode_o
);
  logic             vld_q, par_q, mode_q, par_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    if (up_mode_i) begin
      data_d = {up_data_i[WIDTH-2:0], up_data_i[WIDTH-1]};
      par_d  = up_par_i;
    end else begin
      data_d = {up_data_i[WIDTH-2:0], up_par_i};
      par_d  = up_data_i[WIDTH-1];
    end
  end

  // Payload only moves on a load so a stalled beat stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      par_q  <= 1'b0;
      mode_q <= 1'b0;
    end else if (flush_i) begin
      vld_q  <= 1'b0;
    end else if (ready_i) begin
      vld_q <= up_vld_i;
      if (up_vld_i) begin
        data_q <= data_d;
        par_q  <= par_d;
        mode_q <= up_mode_i;
      end
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;
  assign par_o  = par_q;
  assign mode_o = mode_q;
endmodule

module filter_chain #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 16,
  parameter int CW     = $clog2(STAGES+1)
) (
  input  logic          clk,
  input  logic          reset,
  filter_chain_if.slave bus
);
  logic [STAGES-1:0]            vld_q, par_q, mode_q, rdy;
  logic [STAGES-1:0][WIDTH-1:0] data_q;
  logic [STAGES-1:0]            up_vld, up_par, up_mode;
  logic [STAGES-1:0][WIDTH-1:0] up_data;
  logic                         in_fire, out_fire, unused_mode;
  logic [CW-1:0]                cnt_q, cnt_d;

  assign bus.io_x_ready = rdy[0] & ~bus.io_flush & reset;
  assign in_fire        = bus.io_x_valid & bus.io_x_ready;
  assign out_fire       = vld_q[STAGES-1] & bus.io_y_ready;

  genvar i;
  generate
    for (i = 0; i < STAGES; i++) begin : g_stage
      // Flattened ready chain: stage i stalls only if it and every later stage are full.
      assign rdy[i] = bus.io_y_ready | ~(&vld_q[STAGES-1:i]);
      if (i == 0) begin : g_head
        assign up_vld[i]  = in_fire;
        assign up_data[i] = bus.io_x_data;
        assign up_par[i]  = bus.io_x_parity;
        assign up_mode[i] = bus.io_x_mode;
      end else begin : g_body
        assign up_vld[i]  = vld_q[i-1];
        assign up_data[i] = data_q[i-1];
        assign up_par[i]  = par_q[i-1];
        assign up_mode[i] = mode_q[i-1];
      end
      filter_stage #(.WIDTH(WIDTH)) u_stage (
        .clk       (clk),
        .rst_n     (reset),
        .flush_i   (bus.io_flush),
        .ready_i   (rdy[i]),
        .up_vld_i  (up_vld[i]),
        .up_data_i (up_data[i]),
        .up_par_i  (up_par[i]),
        .up_mode_i (up_mode[i]),
        .vld_o     (vld_q[i]),
        .data_o    (data_q[i]),
        .par_o     (par_q[i]),
        .mode_o    (mode_q[i])
      );
    end
  endgenerate

  assign unused_mode = mode_q[STAGES-1];

  always_comb begin
    cnt_d = cnt_q;
    if (bus.io_flush)               cnt_d = '0;
    else if (in_fire && !out_fire)  cnt_d = cnt_q + CW'(1);
    else if (out_fire && !in_fire)  cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bus.io_y_valid  = vld_q[STAGES-1];
  assign bus.io_y_data   = data_q[STAGES-1];
  assign bus.io_y_parity = par_q[STAGES-1];
  assign bus.io_count    = cnt_q;
endmodule

// File: tb/tb_filter_chain.sv
// Scoreboard bench for filter_chain: driver pushes reference-model results on
// accept, monitor pops and compares on every output transfer.
module tb_filter_chain;
  localparam int STAGES = 2;
  localparam int WIDTH  = 16;
  localparam int CW     = $clog2(STAGES+1);

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             p;
    int               cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  filter_chain_if #(.WIDTH(WIDTH), .CW(CW)) bus();
  filter_chain #(.STAGES(STAGES), .WIDTH(WIDTH), .CW(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   lat_chk = 1'b0;
  bit   in_rst  = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: apply the per-stage rule STAGES times with integer arithmetic.
  function automatic exp_t model(input logic [WIDTH-1:0] d, input logic p, input logic m, input int c);
    exp_t        e;
    int unsigned v, pv, msb, mask;
    mask = (32'd1 << WIDTH) - 1;
    v = d; pv = p;
    for (int s = 0; s < STAGES; s++) begin
      msb = (v >> (WIDTH-1)) & 1;
      if (m) v = ((v << 1) | msb) & mask;
      else begin
        v  = ((v << 1) | pv) & mask;
        pv = msb;
      end
    end
    e.d = v[WIDTH-1:0]; e.p = pv[0]; e.cyc = c;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Call just after a posedge; returns just after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] d, input logic p, input logic m);
    int  n = 0;
    bit  done = 0;
    bus.io_x_valid = 1'b1; bus.io_x_data = d; bus.io_x_parity = p; bus.io_x_mode = m;
    while (!done) begin
      @(negedge clk);
      if (bus.io_x_ready) begin
        q.push_back(model(d, p, m, cyc));
        done = 1;
      end else if (++n > 300) begin
        checks++; errors++;
        $display("FAIL send_timeout: got no ready expected ready within 300 cycles");
        bus.io_x_valid = 1'b0;
        done = 1;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    bus.io_x_valid = 1'b0;
  endtask

  // Monitor: scoreboard pop, stall stability, flush discard.
  logic             hold_prev = 1'b0;
  logic [WIDTH-1:0] prev_d;
  logic             prev_p;
  initial forever begin
    @(negedge clk);
    if (in_rst) hold_prev = 1'b0;
    else begin
      if (hold_prev) begin
        chk("stall_valid", bus.io_y_valid, 1);
        chk("stall_data", bus.io_y_data, prev_d);
        chk("stall_parity", bus.io_y_parity, prev_p);
      end
      if (bus.io_y_valid && bus.io_y_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got data %0h expected no beat", bus.io_y_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_data", bus.io_y_data, e.d);
          chk("out_parity", bus.io_y_parity, e.p);
          if (lat_chk) chk("latency", cyc - e.cyc, STAGES);
        end
      end
      if (bus.io_flush) q.delete();
      hold_prev = bus.io_y_valid && !bus.io_y_ready && !bus.io_flush;
      prev_d = bus.io_y_data;
      prev_p = bus.io_y_parity;
    end
  end

  // Occupancy must track the number of beats in flight.
  initial forever begin
    @(posedge clk); #2;
    if (!in_rst) chk("count", bus.io_count, q.size());
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.io_x_data = '0; bus.io_x_valid = 0; bus.io_x_parity = 0; bus.io_x_mode = 0;
    bus.io_y_ready = 1; bus.io_flush = 0;
    tick(2);
    chk("rst_y_valid", bus.io_y_valid, 0);
    chk("rst_y_data", bus.io_y_data, 0);
    chk("rst_y_parity", bus.io_y_parity, 0);
    chk("rst_count", bus.io_count, 0);
    chk("rst_x_ready", bus.io_x_ready, 0);
    @(negedge clk) reset = 1'b1;
    tick(1);
    in_rst = 1'b0;
    chk("post_rst_x_ready", bus.io_x_ready, 1);

    // Single beat, shift then rotate, with exact output timing.
    lat_chk = 1'b1;
    for (int m = 0; m < 2; m++) begin
      send(16'hA5C3, 1'b1, m[0]);
      @(negedge clk) chk("single_early", bus.io_y_valid, 0);
      @(negedge clk);
      chk("single_valid", bus.io_y_valid, 1);
      chk("single_data", bus.io_y_data, m ? 32'h970E : 32'h970F);
      chk("single_parity", bus.io_y_parity, m ? 1 : 0);
      @(negedge clk) chk("single_once", bus.io_y_valid, 0);
      tick(1);
    end

    // Backpressure: two beats fill the chain, third waits.
    lat_chk = 1'b0;
    bus.io_y_ready = 1'b0;
    fork
      begin
        send(16'h0001, 1'b0, 1'b0);
        send(16'h0002, 1'b0, 1'b0);
        send(16'h0003, 1'b0, 1'b0);
      end
    join_none
    tick(6);
    @(negedge clk);
    chk("bp_x_ready", bus.io_x_ready, 0);
    chk("bp_count", bus.io_count, 2);
    chk("bp_head_data", bus.io_y_data, 32'h0004);
    chk("bp_head_parity", bus.io_y_parity, 0);
    @(posedge clk); #1;
    bus.io_y_ready = 1'b1;
    wait fork;
    tick(4);

    // Back-to-back streaming with random payload and mode.
    lat_chk = 1'b1;
    repeat (100) send(WIDTH'($urandom), 1'($urandom), 1'($urandom));
    tick(4);

    // Random backpressure and input gaps.
    lat_chk = 1'b0;
    fork
      repeat (300) begin
        @(posedge clk); #1;
        bus.io_y_ready = 1'($urandom);
      end
      repeat (80) begin
        send(WIDTH'($urandom), 1'($urandom), 1'($urandom));
        if ($urandom_range(0, 2) == 0) tick(1);
      end
    join
    bus.io_y_ready = 1'b1;
    tick(6);

    // Flush discards held beats and blocks input for that cycle.
    bus.io_y_ready = 1'b0;
    send(16'h1234, 1'b0, 1'b0);
    send(16'h5678, 1'b1, 1'b1);
    bus.io_flush = 1'b1;
    bus.io_x_valid = 1'b1; bus.io_x_data = 16'hFFFF;
    @(negedge clk) chk("flush_x_ready", bus.io_x_ready, 0);
    @(posedge clk); #1;
    bus.io_flush = 1'b0; bus.io_x_valid = 1'b0;
    @(negedge clk);
    chk("flush_y_valid", bus.io_y_valid, 0);
    chk("flush_count", bus.io_count, 0);
    chk("flush_x_ready_after", bus.io_x_ready, 1);
    bus.io_y_ready = 1'b1;
    tick(4);

    // Asynchronous reset while full.
    bus.io_y_ready = 1'b0;
    send(16'hBEEF, 1'b1, 1'b0);
    send(16'hCAFE, 1'b0, 1'b1);
    @(negedge clk); #2;
    in_rst = 1'b1;
    reset = 1'b0;
    #1;
    chk("arst_y_valid", bus.io_y_valid, 0);
    chk("arst_count", bus.io_count, 0);
    chk("arst_x_ready", bus.io_x_ready, 0);
    q.delete();
    @(negedge clk) reset = 1'b1;
    tick(1);
    in_rst = 1'b0;
    bus.io_y_ready = 1'b1;
    lat_chk = 1'b1;
    send(WIDTH'($urandom), 1'($urandom), 1'($urandom));
    tick(4);
    chk("drain_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
